mult_dispatcher: RTL and testbench

Operand dispatcher that sits directly upstream of the 8-bit sequential unsigned multiplier (`multiplier1`). It accepts operand pairs over a valid/ready stream into a small FIFO, issues one `start` pulse per pair to the multiplier, and waits for the multiplier's `ready`. It then captures the 16-bit product together with its operands into an output register with valid/ready handshake. The block serialises back-to-back requests so that upstream logic never has to track multiplier occupancy.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_operand_fifo.sv | 57 +++++
 rtl/mult_dispatcher.sv | 156 +++++++++++++++
 tb/tb_mult_dispatcher.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier operand dispatcher: defaults,
// FSM state encoding and the watchdog counter sizing helper.
package mult_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/mult_operand_fifo.sv
// Operand-pair FIFO: stores {a, b}, registered occupancy count, full/empty
// flags derived from that count. Pointers wrap naturally (DEPTH is 2^n).
module mult_operand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [2*WIDTH-1:0]   i_wdata,
    input  logic                 i_pop,
    output logic [2*WIDTH-1:0]   o_rdata,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is left unreset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/mult_dispatcher.sv
// Serialises operand pairs into a sequential multiplier: FIFO in front, an
// IDLE/ISSUE/WAIT FSM with a watchdog, and a valid/ready result register.
module mult_dispatcher
    import mult_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_product,
    input  logic                 mul_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_out_product;
    logic [WIDTH-1:0]     r_out_a;
    logic [WIDTH-1:0]     r_out_b;
    logic                 r_timeout_err;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [2*WIDTH-1:0]   w_head;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_capture;
    logic                 w_timeout;

    assign w_push = in_valid && !w_fifo_full;

    mult_operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({in_a, in_b}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty && !r_out_valid) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_pop       = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // r_cnt == 0 is the guard cycle: a ready left over from the
                // previous multiply may still be visible there.
                if (r_cnt != '0 && mul_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt   <= '0;
            r_mul_a <= w_head[2*WIDTH-1:WIDTH];
            r_mul_b <= w_head[WIDTH-1:0];
        end else if (r_state == S_WAIT) begin
            r_cnt   <= w_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_out_a       <= '0;
            r_out_b       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            // Capture only happens with the register empty, so no overwrite.
            if (w_capture) begin
                r_out_valid   <= 1'b1;
                r_out_product <= mul_product;
                r_out_a       <= r_mul_a;
                r_out_b       <= r_mul_b;
            end else if (r_out_valid && out_ready) begin
                r_out_valid   <= 1'b0;
            end
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    // Operands are shown straight from the FIFO head during ISSUE so they are
    // valid on the same edge the multiplier samples mul_start.
    assign mul_start   = (r_state == S_ISSUE);
    assign mul_a       = (r_state == S_ISSUE) ? w_head[2*WIDTH-1:WIDTH] : r_mul_a;
    assign mul_b       = (r_state == S_ISSUE) ? w_head[WIDTH-1:0]       : r_mul_b;
    assign in_ready    = !w_fifo_full;
    assign busy        = (r_state != S_IDLE);
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign out_a       = r_out_a;
    assign out_b       = r_out_b;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mult_dispatcher.sv
// Self-checking bench: behavioural multiplier downstream, scoreboard of
// expected {a, b, a*b} in push order, directed and randomized traffic.
module tb_mult_dispatcher;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid, in_ready;
    logic [WIDTH-1:0]   in_a, in_b;
    logic               mul_start;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_ready;
    logic               out_valid, out_ready;
    logic [2*WIDTH-1:0] out_product;
    logic [WIDTH-1:0]   out_a, out_b;
    logic               busy, timeout_err;

    always #5 clk = ~clk;

    mult_dispatcher #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mul_ready   (mul_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_a       (out_a),
        .out_b       (out_b),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [7:0] a, input logic [7:0] b);
        int unsigned p;
        p = a * b;
        return {a, b, p[15:0]};
    endfunction

    // Downstream multiplier model (no reset): result after lat_cfg cycles,
    // ready then held until the next start. stale_mode keeps the old ready
    // visible for one cycle after start; stuck never raises ready.
    int          lat_cfg    = 3;
    bit          stuck      = 1'b0;
    bit          stale_mode = 1'b0;
    int          m_left     = 0;
    logic [7:0]  m_a = '0, m_b = '0;
    initial begin
        mul_ready   = 1'b0;
        mul_product = '0;
    end

    always @(posedge clk) begin
        if (mul_start) begin
            m_a    <= mul_a;
            m_b    <= mul_b;
            m_left <= lat_cfg;
            if (!stale_mode) mul_ready <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                if (!stuck) begin
                    mul_ready   <= 1'b1;
                    mul_product <= 16'(ref_result(m_a, m_b));
                end
            end else begin
                mul_ready <= 1'b0;
            end
        end
    end

    // Scoreboard and start-pulse monitor.
    logic [31:0] exp_q[$];
    int          n_start    = 0;
    logic        prev_start = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_start = 1'b0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(ref_result(in_a, in_b));
            if (out_valid && out_ready) begin
                check("out_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("result", {out_a, out_b, out_product}, exp_q.pop_front());
            end
            if (mul_start) begin
                n_start++;
                check("start_gap", 32'(prev_start), 0);
            end
            prev_start = mul_start;
        end
    end

    // Callers are always mid-cycle (after #1 or at a negedge), never on an edge.
    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int   t = 0;
        logic acc;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        do begin
            @(posedge clk);
            acc = in_ready;
            t++;
        end while (!acc && t < 500);
        #1 in_valid = 1'b0;
        check("push_accept", 32'(acc), 1);
    endtask

    task automatic wait_out_valid(input int max_cyc, input string tag);
        int t = 0;
        while (!out_valid && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(out_valid), 1);
    endtask

    task automatic wait_drain(input int max_cyc);
        int t = 0;
        while (exp_q.size() != 0 && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},    32'(in_ready), 1);
        check({tag, "_out_valid"},   32'(out_valid), 0);
        check({tag, "_busy"},        32'(busy), 0);
        check({tag, "_mul_start"},   32'(mul_start), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
        check({tag, "_mul_ab"},      {16'h0, mul_a, mul_b}, 0);
        check({tag, "_out"},         {out_a, out_b, out_product}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation bound expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        int s0;
        int n;
        int t;
        bit done;

        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single pair, result held with out_ready low.
        s0 = n_start;
        push(8'h0F, 8'h11);
        wait_out_valid(60, "t1_valid");
        check("t1_product", 32'(out_product), 32'h00FF);
        check("t1_a", 32'(out_a), 32'h0F);
        check("t1_b", 32'(out_b), 32'h11);
        check("t1_starts", 32'(n_start - s0), 1);

        // Fill the FIFO behind the held result; no new start may occur.
        push(8'hFF, 8'hFF);
        push(8'h12, 8'h34);
        push(8'h80, 8'h02);
        push(8'h01, 8'h01);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 0);
        repeat (10) @(negedge clk);
        check("held_product", {out_a, out_b, out_product}, 32'h0F1100FF);
        check("held_valid", 32'(out_valid), 1);
        check("held_starts", 32'(n_start - s0), 1);
        check("held_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        push(8'hAB, 8'hCD);
        wait_drain(1000);
        check("burst_starts", 32'(n_start - s0), 6);

        // Randomized traffic with random backpressure and latencies.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    lat_cfg = $urandom_range(1, 6);
                    push(8'($urandom), 8'($urandom));
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain(2000);

        // Stale ready from a nonzero product must be skipped by the guard cycle.
        lat_cfg = 3;
        push(8'hFF, 8'hFF);
        wait_drain(200);
        check("stale_pre_ready", 32'(mul_ready), 1);
        stale_mode = 1'b1;
        push(8'h00, 8'h37);
        wait_drain(200);
        stale_mode = 1'b0;

        // Multiplier never answers: watchdog fires after 32 WAIT cycles.
        stuck = 1'b1;
        s0 = n_start;
        push(8'h21, 8'h43);
        t = 0;
        while (!busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("to_busy_cycles", 32'(n), 33);
        check("to_err", 32'(timeout_err), 1);
        check("to_no_valid", 32'(out_valid), 0);
        check("to_starts", 32'(n_start - s0), 1);
        check("to_pending", 32'(exp_q.size()), 1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        stuck = 1'b0;

        // Reset during WAIT with two pairs still queued.
        lat_cfg = 12;
        push(8'h11, 8'h22);
        push(8'h33, 8'h44);
        push(8'h55, 8'h66);
        t = 0;
        while (!busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("rst_pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        s0 = n_start;
        repeat (30) @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 0);
        check("post_rst_starts", 32'(n_start - s0), 0);
        check("post_rst_busy", 32'(busy), 0);
        lat_cfg = 2;
        push(8'h05, 8'h07);
        wait_drain(200);
        check("post_rst_new_start", 32'(n_start - s0), 1);

        check("final_queue", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
